// File: rtl/latency_ram_pkg.sv
// Shared width helpers for latency_ram: line, data, byte-enable and port-index widths
// derived from the top-level parameters.
package latency_ram_pkg;

    function automatic int lw_f(input int address_width, input int data_width_shift);
        return address_width - data_width_shift;
    endfunction

    function automatic int dw_f(input int data_width_shift);
        return 8 * (1 << data_width_shift);
    endfunction

    function automatic int be_f(input int data_width_shift);
        return 1 << data_width_shift;
    endfunction

    // A single-port instance still carries a one-bit port field.
    function automatic int pw_f(input int num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

endpackage

// File: rtl/latency_ram_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from rr_ptr; the pointer moves past the
// granted port only when the grant is actually taken (advance_i).
module rr_arbiter
    import latency_ram_pkg::*;
#(
    parameter int NUM_PORTS = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic                 advance_i,
    output logic [NUM_PORTS-1:0] grant_o
);

    localparam int PW = pw_f(NUM_PORTS);

    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] grant_idx;
    logic [PW:0]   cand;
    logic [PW:0]   nxt;
    logic          found;

    always_comb begin
        grant_o   = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = {1'b0, rr_ptr} + (PW+1)'(i);
            if (cand >= (PW+1)'(NUM_PORTS)) begin
                cand = cand - (PW+1)'(NUM_PORTS);
            end
            if (!found && req_i[cand[PW-1:0]]) begin
                found                  = 1'b1;
                grant_o[cand[PW-1:0]]  = 1'b1;
                grant_idx              = cand[PW-1:0];
            end
        end
    end

    always_comb begin
        nxt = {1'b0, grant_idx} + (PW+1)'(1);
        if (nxt >= (PW+1)'(NUM_PORTS)) begin
            nxt = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr <= '0;
        end else if (advance_i) begin
            rr_ptr <= nxt[PW-1:0];
        end
    end

endmodule

// File: rtl/latency_ram.sv
// Multi-port line-wide RAM with round-robin arbitration and an exact, fixed response
// latency; blocking (one in flight) or fully pipelined.
module latency_ram
    import latency_ram_pkg::*;
#(
    parameter int ADDRESS_WIDTH    = 20,
    parameter int DATA_WIDTH_SHIFT = 4,
    parameter int NUM_PORTS        = 2,
    parameter int LATENCY          = 5,
    parameter int PIPELINED        = 1
) (
    input  logic                                                      clk_i,
    input  logic                                                      rst_ni,
    input  logic [NUM_PORTS-1:0]                                      req_valid_i,
    output logic [NUM_PORTS-1:0]                                      req_ready_o,
    input  logic [NUM_PORTS-1:0]                                      req_we_i,
    input  logic [NUM_PORTS*lw_f(ADDRESS_WIDTH, DATA_WIDTH_SHIFT)-1:0] req_addr_i,
    input  logic [NUM_PORTS*dw_f(DATA_WIDTH_SHIFT)-1:0]               req_data_i,
    input  logic [NUM_PORTS*be_f(DATA_WIDTH_SHIFT)-1:0]               req_be_i,
    output logic [NUM_PORTS-1:0]                                      rsp_valid_o,
    output logic [NUM_PORTS*dw_f(DATA_WIDTH_SHIFT)-1:0]               rsp_data_o
);

    localparam int LW = lw_f(ADDRESS_WIDTH, DATA_WIDTH_SHIFT);
    localparam int DW = dw_f(DATA_WIDTH_SHIFT);
    localparam int BE = be_f(DATA_WIDTH_SHIFT);
    localparam int PW = pw_f(NUM_PORTS);

    typedef struct packed {
        logic [PW-1:0] port;
        logic          we;
        logic [DW-1:0] data;
    } stage_t;

    logic [DW-1:0]        mem [2**LW];
    logic [LATENCY-1:0]   vld_p;
    stage_t               stage_p [LATENCY];

    logic [NUM_PORTS-1:0] grant;
    logic                 slot_free;
    logic                 acc_fire;
    logic [PW-1:0]        sel;
    logic                 acc_we;
    logic [LW-1:0]        acc_addr;
    logic [DW-1:0]        acc_wdata;
    logic [BE-1:0]        acc_be;

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) u_arb (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (req_valid_i),
        .advance_i (acc_fire),
        .grant_o   (grant)
    );

    // In blocking mode the only in-flight access may be the one leaving this cycle.
    assign slot_free   = (PIPELINED != 0) || !(|vld_p) || vld_p[LATENCY-1];
    assign req_ready_o = grant & {NUM_PORTS{slot_free}};
    assign acc_fire    = |(req_ready_o & req_valid_i);

    always_comb begin
        sel = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (grant[p]) begin
                sel = PW'(p);
            end
        end
    end

    assign acc_we    = req_we_i[sel];
    assign acc_addr  = req_addr_i[int'(sel)*LW +: LW];
    assign acc_wdata = req_data_i[int'(sel)*DW +: DW];
    assign acc_be    = req_be_i[int'(sel)*BE +: BE];

    always_ff @(posedge clk_i) begin
        if (acc_fire && acc_we) begin
            for (int b = 0; b < BE; b++) begin
                if (acc_be[b]) begin
                    mem[acc_addr][b*8 +: 8] <= acc_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Stage 0 captures the access at the accepting edge; later stages only shift.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= acc_fire;
            for (int i = 1; i < LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        stage_p[0].port <= sel;
        stage_p[0].we   <= acc_we;
        stage_p[0].data <= acc_we ? '0 : mem[acc_addr];
        for (int i = 1; i < LATENCY; i++) begin
            stage_p[i] <= stage_p[i-1];
        end
    end

    // Exit stage: data is gated by valid so idle or reset outputs read as zero.
    always_comb begin
        rsp_valid_o = '0;
        rsp_data_o  = '0;
        if (vld_p[LATENCY-1]) begin
            rsp_valid_o[stage_p[LATENCY-1].port]                  = 1'b1;
            rsp_data_o[int'(stage_p[LATENCY-1].port)*DW +: DW]    = stage_p[LATENCY-1].data;
        end
    end

endmodule
